text_writer: RTL and testbench

- Write-side companion to the videotext display path: accepts a character stream over a valid/ready handshake and writes it into the text RAM that the video generator scans.
- Maintains a cursor.
- Interprets a small set of control codes: CR, LF, BS, FF.
- Clears the screen on reset and on FF.
- Scrolls the screen up one row when output runs past the last row.
- Drives the text RAM's write port and a private read port; the read port is used only for scrolling.

---
 rtl/text_writer_pkg.sv | 32 +++
 rtl/text_writer_if.sv | 38 +++
 rtl/text_writer_cursor.sv | 82 ++++++++
 rtl/text_writer.sv | 200 ++++++++++++++++++++
 tb/tb_text_writer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_writer_pkg.sv
// ---------------------------------------------------------------------------
// text_writer_pkg
// Shared definitions for the text writer: default screen geometry, the fill
// character, the control codes the writer understands, the FSM state
// encoding and a small helper that classifies printable characters.
// No ports (package).
// ---------------------------------------------------------------------------
package text_writer_pkg;

    localparam int         DEF_COLS  = 40;
    localparam int         DEF_ROWS  = 25;
    localparam logic [7:0] DEF_BLANK = 8'h20;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] BS = 8'h08;
    localparam logic [7:0] FF = 8'h0C;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        CLEAR        = 2'd1,
        SCROLL_COPY  = 2'd2,
        SCROLL_BLANK = 2'd3
    } state_t;

    // Characters 0x20..0x7E are drawn on screen; everything else is a
    // control code or ignored.
    function automatic logic isPrintable(input logic [7:0] ch);
        return (ch >= 8'h20) && (ch <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_writer_if.sv
// ---------------------------------------------------------------------------
// text_writer_if
// Bundles the character input handshake, the text RAM write and read ports
// and the status outputs of the text writer.
//   in_valid/in_char/in_ready : character stream handshake
//   wr_en/wr_addr/wr_data     : text RAM write port
//   rd_addr/rd_data           : text RAM read port (scroll source, 1-cycle latency)
//   cursor_col/cursor_row     : current cursor position
//   busy                      : clear or scroll in progress
// Modport slave is the writer's view, master is the producer/RAM side view.
// ---------------------------------------------------------------------------
interface text_writer_if;

    logic       in_valid;
    logic [7:0] in_char;
    logic       in_ready;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic [9:0] rd_addr;
    logic [7:0] rd_data;
    logic [5:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;

    modport slave (
        input  in_valid, in_char, rd_data,
        output in_ready, wr_en, wr_addr, wr_data, rd_addr,
               cursor_col, cursor_row, busy
    );

    modport master (
        output in_valid, in_char, rd_data,
        input  in_ready, wr_en, wr_addr, wr_data, rd_addr,
               cursor_col, cursor_row, busy
    );

endinterface

// File: rtl/text_writer_cursor.sv
// ---------------------------------------------------------------------------
// text_writer_cursor
// Holds the cursor column, row and the linear text RAM address of the cursor
// cell. The address is tracked incrementally next to a row base register so
// no multiplier is needed.
//   clk, reset          : clock, synchronous active-high reset
//   i_home              : move to (0,0)
//   i_advance           : step right after a printable, wrapping to next row
//   i_cr, i_lf, i_bs    : carriage return, line feed, backspace
//   o_col, o_row, o_addr: cursor position and linear address
//   o_lastCol, o_lastRow: cursor sits in the last column / last row
// On the last row a wrap or line feed keeps the row; the caller scrolls.
// ---------------------------------------------------------------------------
module text_writer_cursor #(
    parameter int COLS = 40,
    parameter int ROWS = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_home,
    input  logic       i_advance,
    input  logic       i_cr,
    input  logic       i_lf,
    input  logic       i_bs,
    output logic [5:0] o_col,
    output logic [4:0] o_row,
    output logic [9:0] o_addr,
    output logic       o_lastCol,
    output logic       o_lastRow
);

    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [9:0] ROW_STEP = 10'(COLS);

    logic [5:0] r_col;
    logic [4:0] r_row;
    logic [9:0] r_rowBase;
    logic [9:0] r_addr;
    logic       w_lastCol;
    logic       w_lastRow;

    assign w_lastCol = (r_col == LAST_COL);
    assign w_lastRow = (r_row == LAST_ROW);

    // Cursor update. Reset and home dominate. A printable in the last column
    // behaves like a line feed; on the last row the row is kept because the
    // screen content moves up instead.
    always_ff @(posedge clk) begin
        if (reset || i_home) begin
            r_col     <= '0;
            r_row     <= '0;
            r_rowBase <= '0;
            r_addr    <= '0;
        end else if (i_advance && !w_lastCol) begin
            r_col  <= r_col + 6'd1;
            r_addr <= r_addr + 10'd1;
        end else if (i_advance || i_lf) begin
            r_col <= '0;
            if (w_lastRow) begin
                r_addr <= r_rowBase;
            end else begin
                r_row     <= r_row + 5'd1;
                r_rowBase <= r_rowBase + ROW_STEP;
                r_addr    <= r_rowBase + ROW_STEP;
            end
        end else if (i_cr) begin
            r_col  <= '0;
            r_addr <= r_rowBase;
        end else if (i_bs && (r_col != 6'd0)) begin
            r_col  <= r_col - 6'd1;
            r_addr <= r_addr - 10'd1;
        end
    end

    assign o_col     = r_col;
    assign o_row     = r_row;
    assign o_addr    = r_addr;
    assign o_lastCol = w_lastCol;
    assign o_lastRow = w_lastRow;

endmodule

// File: rtl/text_writer.sv
// ---------------------------------------------------------------------------
// text_writer
// Accepts a character stream and writes it into the text RAM scanned by the
// video generator. Handles CR, LF, BS and FF, clears the screen after reset
// and on FF, and scrolls the screen up one row when output runs past the
// last row.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : text_writer_if.slave (handshake, RAM write/read ports, cursor,
//           busy)
// All interface outputs come straight from registers.
// ---------------------------------------------------------------------------
module text_writer
    import text_writer_pkg::*;
#(
    parameter int         COLS  = DEF_COLS,
    parameter int         ROWS  = DEF_ROWS,
    parameter logic [7:0] BLANK = DEF_BLANK
) (
    input logic          clk,
    input logic          reset,
    text_writer_if.slave bus
);

    localparam logic [9:0] LAST_ADDR = 10'(COLS * ROWS - 1);
    localparam logic [9:0] LAST_COPY = 10'((ROWS - 1) * COLS - 1);
    localparam logic [9:0] FIRST_SRC = 10'(COLS);

    state_t     r_state;
    logic [9:0] r_idx;
    logic       r_wrEn;
    logic [9:0] r_wrAddr;
    logic [7:0] r_wrData;
    logic [9:0] r_rdAddr;
    logic       r_rdIssued;
    logic       r_dataValid;
    logic       r_inReady;
    logic       r_busy;

    logic       w_accept;
    logic       w_printable;
    logic       w_isCr;
    logic       w_isLf;
    logic       w_isBs;
    logic       w_isFf;
    logic       w_scrollReq;
    logic       w_home;
    logic [5:0] w_col;
    logic [4:0] w_row;
    logic [9:0] w_curAddr;
    logic       w_lastCol;
    logic       w_lastRow;

    assign w_accept    = (r_state == IDLE) && r_inReady && bus.in_valid;
    assign w_printable = isPrintable(bus.in_char);
    assign w_isCr      = (bus.in_char == CR);
    assign w_isLf      = (bus.in_char == LF);
    assign w_isBs      = (bus.in_char == BS);
    assign w_isFf      = (bus.in_char == FF);

    // Output runs past the bottom either by a printable in the very last
    // cell or by a line feed anywhere on the last row.
    assign w_scrollReq = w_accept &&
                         ((w_printable && w_lastCol && w_lastRow) ||
                          (w_isLf && w_lastRow));

    // The cursor returns home together with the final clear write, so it
    // stays where it was for the whole clear triggered by FF.
    assign w_home = (r_state == CLEAR) && (r_idx == LAST_ADDR);

    text_writer_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk       (clk),
        .reset     (reset),
        .i_home    (w_home),
        .i_advance (w_accept && w_printable),
        .i_cr      (w_accept && w_isCr),
        .i_lf      (w_accept && w_isLf),
        .i_bs      (w_accept && w_isBs),
        .o_col     (w_col),
        .o_row     (w_row),
        .o_addr    (w_curAddr),
        .o_lastCol (w_lastCol),
        .o_lastRow (w_lastRow)
    );

    // Main FSM with all RAM and handshake outputs registered.
    // r_idx is the write destination for clear, scroll copy and scroll blank;
    // the copy phase continues straight into the blank phase at the next row.
    // The copy pipeline: r_rdIssued marks a cycle whose rd_addr is a real
    // read, r_dataValid marks the following cycle where rd_data holds it,
    // and that data is registered onto the write port.
    // IDLE spends one cycle raising in_ready after a clear or scroll, so
    // in_ready never overlaps the final BLANK write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= CLEAR;
            r_idx       <= '0;
            r_wrEn      <= 1'b0;
            r_wrAddr    <= '0;
            r_wrData    <= BLANK;
            r_rdAddr    <= '0;
            r_rdIssued  <= 1'b0;
            r_dataValid <= 1'b0;
            r_inReady   <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_wrEn <= 1'b0;
            case (r_state)
                CLEAR: begin
                    r_wrEn   <= 1'b1;
                    r_wrAddr <= r_idx;
                    r_wrData <= BLANK;
                    if (r_idx == LAST_ADDR) begin
                        r_state <= IDLE;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + 10'd1;
                    end
                end

                IDLE: begin
                    if (!r_inReady) begin
                        r_inReady <= 1'b1;
                        r_busy    <= 1'b0;
                    end else if (w_accept) begin
                        if (w_printable) begin
                            r_wrEn   <= 1'b1;
                            r_wrAddr <= w_curAddr;
                            r_wrData <= bus.in_char;
                        end
                        if (w_scrollReq) begin
                            r_state     <= SCROLL_COPY;
                            r_idx       <= '0;
                            r_rdAddr    <= FIRST_SRC;
                            r_rdIssued  <= 1'b1;
                            r_dataValid <= 1'b0;
                            r_inReady   <= 1'b0;
                            r_busy      <= 1'b1;
                        end else if (w_isFf) begin
                            r_state   <= CLEAR;
                            r_idx     <= '0;
                            r_inReady <= 1'b0;
                            r_busy    <= 1'b1;
                        end
                    end
                end

                SCROLL_COPY: begin
                    r_dataValid <= r_rdIssued;
                    if (r_rdIssued) begin
                        if (r_rdAddr == LAST_ADDR) begin
                            r_rdIssued <= 1'b0;
                        end else begin
                            r_rdAddr <= r_rdAddr + 10'd1;
                        end
                    end
                    if (r_dataValid) begin
                        r_wrEn   <= 1'b1;
                        r_wrAddr <= r_idx;
                        r_wrData <= bus.rd_data;
                        r_idx    <= r_idx + 10'd1;
                        if (r_idx == LAST_COPY) begin
                            r_state <= SCROLL_BLANK;
                        end
                    end
                end

                SCROLL_BLANK: begin
                    r_wrEn   <= 1'b1;
                    r_wrAddr <= r_idx;
                    r_wrData <= BLANK;
                    if (r_idx == LAST_ADDR) begin
                        r_state <= IDLE;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + 10'd1;
                    end
                end

                default: begin
                    r_state <= CLEAR;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_inReady;
    assign bus.wr_en      = r_wrEn;
    assign bus.wr_addr    = r_wrAddr;
    assign bus.wr_data    = r_wrData;
    assign bus.rd_addr    = r_rdAddr;
    assign bus.cursor_col = w_col;
    assign bus.cursor_row = w_row;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_text_writer.sv
// ---------------------------------------------------------------------------
// tb_text_writer
// Self-checking bench for text_writer. A behavioural text RAM answers the
// read port; an independent screen/cursor model predicts every RAM write,
// which is queued when a character is driven and compared when the writer
// produces it.
// ---------------------------------------------------------------------------
module tb_text_writer;
    import text_writer_pkg::*;

    localparam int COLS  = 40;
    localparam int ROWS  = 25;
    localparam int TOTAL = COLS * ROWS;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
        bit         chained;
    } wrExp_t;

    logic clk = 1'b0;
    logic reset;

    text_writer_if bus ();

    text_writer #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .BLANK (8'h20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, active edge is posedge.
    always #5 clk = ~clk;

    // Behavioural text RAM with a registered (1-cycle) read port.
    logic [7:0] ramModel [1024];
    always @(posedge clk) begin
        if (bus.wr_en === 1'b1) ramModel[bus.wr_addr] <= bus.wr_data;
        bus.rd_data <= ramModel[bus.rd_addr];
    end

    wrExp_t     sbQ [$];
    wrExp_t     monEntry;
    logic [7:0] expScreen [TOTAL];
    int         expCol;
    int         expRow;
    int         checkCount  = 0;
    int         passCount   = 0;
    int         cycleCount  = 0;
    int         lastWrCycle = -10;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Write monitor: every RAM write must match the head of the scoreboard,
    // and writes flagged as chained must follow the previous one directly.
    always @(negedge clk) begin
        cycleCount++;
        if (bus.wr_en === 1'b1) begin
            checkOutput("wrExpected", 32'(sbQ.size() != 0), 32'd1);
            if (sbQ.size() != 0) begin
                monEntry = sbQ.pop_front();
                checkOutput("wrAddr", 32'(bus.wr_addr), 32'(monEntry.addr));
                checkOutput("wrData", 32'(bus.wr_data), 32'(monEntry.data));
                if (monEntry.chained)
                    checkOutput("wrGap", 32'(cycleCount - lastWrCycle), 32'd1);
            end
            lastWrCycle = cycleCount;
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic pushWrite(input int addr, input logic [7:0] data, input bit chained);
        sbQ.push_back('{addr: 10'(addr), data: data, chained: chained});
    endtask

    task automatic clearModel;
        for (int i = 0; i < TOTAL; i++) begin
            pushWrite(i, 8'h20, i != 0);
            expScreen[i] = 8'h20;
        end
        expCol = 0;
        expRow = 0;
    endtask

    task automatic scrollModel;
        logic [7:0] v;
        for (int i = 0; i < (ROWS - 1) * COLS; i++) begin
            v = expScreen[i + COLS];
            pushWrite(i, v, i != 0);
            expScreen[i] = v;
        end
        for (int i = (ROWS - 1) * COLS; i < TOTAL; i++) begin
            pushWrite(i, 8'h20, 1'b1);
            expScreen[i] = 8'h20;
        end
    endtask

    task automatic modelChar(input logic [7:0] c, input bit chained);
        if (isPrintable(c)) begin
            pushWrite(expRow * COLS + expCol, c, chained);
            expScreen[expRow * COLS + expCol] = c;
            if (expCol == COLS - 1) begin
                expCol = 0;
                if (expRow == ROWS - 1) scrollModel();
                else expRow++;
            end else begin
                expCol++;
            end
        end else if (c == CR) begin
            expCol = 0;
        end else if (c == LF) begin
            expCol = 0;
            if (expRow == ROWS - 1) scrollModel();
            else expRow++;
        end else if (c == BS) begin
            if (expCol > 0) expCol--;
        end else if (c == FF) begin
            clearModel();
        end
    endtask

    // Waits (bounded) for in_ready, drives one character for one accept
    // edge and records the expected effect. Consecutive calls keep in_valid
    // high, giving back-to-back transfers.
    task automatic applyStimulus(input logic [7:0] c, input bit chained);
        int guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 3000) begin
            tick();
            guard++;
        end
        if (guard >= 3000) checkOutput("inReadyWait", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_char  = c;
        modelChar(c, chained);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Counts cycles with in_ready low until it rises.
    task automatic waitIdle(input string tag, input int expected);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 5000) begin
            n++;
            tick();
        end
        checkOutput(tag, 32'(n), 32'(expected));
        checkOutput("busyIdle", 32'(bus.busy), 32'd0);
    endtask

    task automatic waitDrain;
        int n = 0;
        while (sbQ.size() != 0 && n < 50) begin
            n++;
            tick();
        end
        tick();
        checkOutput("sbDrain", 32'(sbQ.size()), 32'd0);
    endtask

    task automatic checkCursor;
        checkOutput("cursorCol", 32'(bus.cursor_col), 32'(expCol));
        checkOutput("cursorRow", 32'(bus.cursor_row), 32'(expRow));
    endtask

    function automatic logic [7:0] charAt(input int i);
        return 8'(8'h41 + (i % 26));
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached");
        $display("%0d/%0d checks passed", passCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;
        reset        = 1'b1;
        clearModel();

        // Reset held for one edge, then the power-up clear.
        tick();
        reset = 1'b0;
        checkOutput("rstBusy", 32'(bus.busy), 32'd1);
        checkOutput("rstReady", 32'(bus.in_ready), 32'd0);
        checkOutput("rstWrEn", 32'(bus.wr_en), 32'd0);
        checkOutput("rstWrData", 32'(bus.wr_data), 32'h20);
        checkOutput("rstRdAddr", 32'(bus.rd_addr), 32'd0);
        waitIdle("clearCycles", 1001);
        waitDrain();
        checkCursor();

        $display("[TB] back-to-back printables");
        applyStimulus(8'h41, 1'b0);
        applyStimulus(8'h42, 1'b1);
        waitDrain();
        checkCursor();

        $display("[TB] full row, CR, BS");
        applyStimulus(CR, 1'b0);
        for (int i = 0; i < COLS; i++) applyStimulus(charAt(i), i != 0);
        waitDrain();
        checkCursor();
        applyStimulus(CR, 1'b0);
        applyStimulus(BS, 1'b0);
        waitDrain();
        checkCursor();

        $display("[TB] form feed at (5,3)");
        applyStimulus(LF, 1'b0);
        applyStimulus(LF, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(charAt(i + 7), i != 0);
        waitDrain();
        checkCursor();
        applyStimulus(FF, 1'b0);
        waitIdle("ffClearCycles", 1001);
        waitDrain();
        checkCursor();

        $display("[TB] scroll from last cell");
        for (int i = 0; i < ROWS - 1; i++) applyStimulus(LF, 1'b0);
        for (int i = 0; i < COLS - 1; i++) applyStimulus(charAt(i + 3), i != 0);
        waitDrain();
        checkCursor();
        applyStimulus(8'h5A, 1'b0);
        waitIdle("scrollCycles", 1002);
        waitDrain();
        checkCursor();

        $display("[TB] reset during scroll");
        applyStimulus(LF, 1'b0);
        repeat (100) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sbQ.delete();
        clearModel();
        checkOutput("midRstWrEn", 32'(bus.wr_en), 32'd0);
        checkOutput("midRstReady", 32'(bus.in_ready), 32'd0);
        checkOutput("midRstRdAddr", 32'(bus.rd_addr), 32'd0);
        waitIdle("midRstClearCycles", 1001);
        waitDrain();
        checkCursor();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
